ads_dev_emu: RTL and testbench

//  Synthesizable emulator of the dual-channel serial SAR ADC, i.e. the device side of the ADS link.

---
 rtl/ads_dev_emu.sv | 236 +++++++++++++++++++++++
 tb/tb_ads_dev_emu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ads_dev_emu.sv
`default_nettype none
// ============================================================================
// Module   : ads_dev_emu
// Purpose  : device-side emulator of the dual-channel serial SAR ADC (ADS link)
// Revision : 1.0  initial release
// ============================================================================
module ads_dev_emu #(
    parameter int CONV_CYCLES = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_100M,
    input  logic        CLK_RST,
    input  logic        ADS_CLK,
    input  logic        ADS_CS_N,
    input  logic        ADS_CONVST,
    input  logic        ADS_RD,
    input  logic        ADS_SDI,
    input  logic [1:0]  ADS_M,
    output logic        ADS_BUSY,
    output logic        ADS_SDOA,
    output logic        ADS_SDOB,
    input  logic [15:0] DATA_A,
    input  logic [15:0] DATA_B,
    output logic [11:0] CFG_CR,
    output logic [11:0] REFDAC1,
    output logic [11:0] REFDAC2,
    output logic [15:0] CMD_WORD,
    output logic        CMD_STB,
    output logic [15:0] CONV_CNT,
    output logic [7:0]  CONV_OVR
);

    localparam int         c_CNT_W    = $clog2(CONV_CYCLES + 1);
    // CS_N idles high so the synchronizer must not fake a CS fall out of reset
    localparam logic [6:0] c_SYNC_RST = 7'b000_0010;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CONV = 1'b1} state_t;

    logic [6:0]         w_in;
    logic [6:0]         r_sync [SYNC_STAGES];
    logic [6:0]         r_prev;
    logic [6:0]         w_s;
    logic               w_clk_rise, w_clk_fall, w_cs_rise, w_cs_fall, w_cs_low;
    logic               w_cv_rise, w_rd_rise, w_sdi;

    logic [1:0]         r_stat;
    logic               w_unused;

    logic [4:0]         r_bit_cnt;
    logic [15:0]        r_sr;
    logic               w_decode;

    state_t             r_state, w_state_nxt;
    logic               w_start, w_term, w_ignored;
    logic [c_CNT_W-1:0] r_cnt;
    logic [15:0]        r_conv_cnt, w_cnt_inc;
    logic [7:0]         r_ovr;
    logic               r_ch, r_tag_mode;
    logic [15:0]        r_res_a, r_res_b;
    logic [1:0]         r_tag_a, r_tag_b;
    logic [1:0]         r_pend;
    logic [11:0]        r_cfg, r_refdac1, r_refdac2;
    logic [15:0]        r_cmd_word;
    logic               r_cmd_stb;

    logic [17:0]        r_sh_a, r_sh_b;
    logic               r_armed;

    assign w_in = {ADS_M, ADS_SDI, ADS_RD, ADS_CONVST, ADS_CS_N, ADS_CLK};

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= c_SYNC_RST;
            r_prev <= c_SYNC_RST;
            r_stat <= 2'b00;
        end else begin
            r_sync[0] <= w_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
            r_stat <= r_sync[SYNC_STAGES-1][6:5];
        end
    end

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_clk_rise =  w_s[0] & ~r_prev[0];
    assign w_clk_fall = ~w_s[0] &  r_prev[0];
    assign w_cs_rise  =  w_s[1] & ~r_prev[1];
    assign w_cs_fall  = ~w_s[1] &  r_prev[1];
    assign w_cs_low   = ~w_s[1];
    assign w_cv_rise  =  w_s[2] & ~r_prev[2];
    assign w_rd_rise  =  w_s[3] & ~r_prev[3];
    assign w_sdi      =  w_s[4];

    // STAT has no port on this block; the mode pins are captured but not exported
    assign w_unused = &{1'b0, r_stat};

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            r_bit_cnt <= 5'd0;
            r_sr      <= 16'h0000;
        end else if (w_cs_fall) begin
            r_bit_cnt <= 5'd0;
            r_sr      <= 16'h0000;
        end else if (w_clk_fall && w_cs_low && r_bit_cnt != 5'd16) begin
            r_sr      <= {r_sr[14:0], w_sdi};
            r_bit_cnt <= r_bit_cnt + 5'd1;
        end
    end

    assign w_decode  = w_cs_rise && (r_bit_cnt == 5'd16);
    assign w_cnt_inc = r_conv_cnt + 16'd1;

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_term      = 1'b0;
        w_ignored   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cv_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                w_ignored = w_cv_rise;
                if (r_cnt == '0) begin
                    w_term      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Soft reset is placed after the conversion update so it wins on CONV_CNT
    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            r_cnt      <= '0;
            r_conv_cnt <= 16'h0000;
            r_ovr      <= 8'h00;
            r_ch       <= 1'b0;
            r_tag_mode <= 1'b0;
            r_res_a    <= 16'h0000;
            r_res_b    <= 16'h0000;
            r_tag_a    <= 2'b00;
            r_tag_b    <= 2'b00;
            r_pend     <= 2'd0;
            r_cfg      <= 12'h000;
            r_refdac1  <= 12'h000;
            r_refdac2  <= 12'h000;
            r_cmd_word <= 16'h0000;
            r_cmd_stb  <= 1'b0;
        end else begin
            r_cmd_stb <= 1'b0;
            if (w_start)
                r_cnt <= c_CNT_W'(CONV_CYCLES - 1);
            else if (r_state == ST_CONV && !w_term)
                r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_term) begin
                r_res_a    <= DATA_A;
                r_res_b    <= DATA_B;
                r_tag_a    <= r_tag_mode ? w_cnt_inc[1:0] : {1'b0, r_ch};
                r_tag_b    <= r_tag_mode ? w_cnt_inc[1:0] : {1'b1, r_ch};
                r_ch       <= ~r_ch;
                r_conv_cnt <= w_cnt_inc;
            end
            if (w_ignored && r_ovr != 8'hFF)
                r_ovr <= r_ovr + 8'd1;
            if (w_decode) begin
                r_cmd_word <= r_sr;
                r_cmd_stb  <= 1'b1;
                if (r_pend != 2'd0) begin
                    if (r_pend == 2'd1) r_refdac1 <= r_sr[11:0];
                    else                r_refdac2 <= r_sr[11:0];
                    r_pend <= 2'd0;
                end else if (r_sr == 16'h0004) begin
                    r_cfg      <= 12'h000;
                    r_refdac1  <= 12'h000;
                    r_refdac2  <= 12'h000;
                    r_pend     <= 2'd0;
                    r_conv_cnt <= 16'h0000;
                    r_tag_mode <= 1'b0;
                end else if (r_sr == 16'h0002) begin
                    r_pend <= 2'd1;
                end else if (r_sr == 16'h0005) begin
                    r_pend <= 2'd2;
                end else if (r_sr[15:12] == 4'h4) begin
                    r_cfg <= r_sr[11:0];
                end else begin
                    r_tag_mode <= r_sr[4];
                end
            end
        end
    end

    // A load in the terminal-count cycle still sees the previous result registers
    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            r_sh_a  <= 18'h00000;
            r_sh_b  <= 18'h00000;
            r_armed <= 1'b0;
        end else if (w_cs_low) begin
            if (w_rd_rise) begin
                r_sh_a  <= {r_tag_a, r_res_a};
                r_sh_b  <= {r_tag_b, r_res_b};
                r_armed <= 1'b0;
            end else begin
                if (w_clk_fall)
                    r_armed <= 1'b1;
                if (w_clk_rise && r_armed) begin
                    r_sh_a <= {r_sh_a[16:0], 1'b0};
                    r_sh_b <= {r_sh_b[16:0], 1'b0};
                end
            end
        end
    end

    assign ADS_BUSY = (r_state == ST_CONV);
    assign ADS_SDOA = w_cs_low & r_sh_a[17];
    assign ADS_SDOB = w_cs_low & r_sh_b[17];
    assign CFG_CR   = r_cfg;
    assign REFDAC1  = r_refdac1;
    assign REFDAC2  = r_refdac2;
    assign CMD_WORD = r_cmd_word;
    assign CMD_STB  = r_cmd_stb;
    assign CONV_CNT = r_conv_cnt;
    assign CONV_OVR = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_ads_dev_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads_dev_emu
// Purpose  : self-checking bench for the ADS device emulator
// Revision : 1.0  initial release
// ============================================================================
module tb_ads_dev_emu;

    logic        CLK_100M   = 1'b0;
    logic        CLK_RST    = 1'b1;
    logic        ADS_CLK    = 1'b0;
    logic        ADS_CS_N   = 1'b1;
    logic        ADS_CONVST = 1'b0;
    logic        ADS_RD     = 1'b0;
    logic        ADS_SDI    = 1'b0;
    logic [1:0]  ADS_M      = 2'b01;
    logic [15:0] DATA_A     = 16'h0000;
    logic [15:0] DATA_B     = 16'h0000;
    logic        ADS_BUSY, ADS_SDOA, ADS_SDOB, CMD_STB;
    logic [11:0] CFG_CR, REFDAC1, REFDAC2;
    logic [15:0] CMD_WORD, CONV_CNT;
    logic [7:0]  CONV_OVR;

    ads_dev_emu #(.CONV_CYCLES(40), .SYNC_STAGES(2)) dut (
        .CLK_100M(CLK_100M), .CLK_RST(CLK_RST),
        .ADS_CLK(ADS_CLK), .ADS_CS_N(ADS_CS_N), .ADS_CONVST(ADS_CONVST),
        .ADS_RD(ADS_RD), .ADS_SDI(ADS_SDI), .ADS_M(ADS_M),
        .ADS_BUSY(ADS_BUSY), .ADS_SDOA(ADS_SDOA), .ADS_SDOB(ADS_SDOB),
        .DATA_A(DATA_A), .DATA_B(DATA_B),
        .CFG_CR(CFG_CR), .REFDAC1(REFDAC1), .REFDAC2(REFDAC2),
        .CMD_WORD(CMD_WORD), .CMD_STB(CMD_STB),
        .CONV_CNT(CONV_CNT), .CONV_OVR(CONV_OVR)
    );

    always #5 CLK_100M = ~CLK_100M;

    int total   = 0;
    int bad     = 0;
    int stb_cnt = 0;

    always @(negedge CLK_100M) if (CMD_STB) stb_cnt++;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        int          stb;
        logic [11:0] cfg;
        logic [11:0] r1;
        logic [11:0] r2;
    } cmd_vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sdi;
        logic [17:0] exp_a;
        logic [17:0] exp_b;
        logic [15:0] exp_cnt;
    } conv_vec_t;

    cmd_vec_t    cv [7];
    conv_vec_t   rv [7];
    logic [17:0] ga, gb;
    int          width, stb0, stb_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK_100M);
    endtask

    // One ADS frame: optional RD load, nbits clocks, SDO sampled before each fall
    task automatic frame(input logic [15:0] word, input int nbits, input bit do_rd,
                         input int stop_at, output logic [17:0] oa, output logic [17:0] ob);
        oa = '0;
        ob = '0;
        ADS_CS_N = 1'b0;
        wait_cyc(6);
        if (do_rd) begin
            ADS_RD = 1'b1; wait_cyc(6);
            ADS_RD = 1'b0; wait_cyc(6);
        end
        for (int i = 0; i < nbits; i++) begin
            ADS_SDI = (i < 16) ? word[15-i] : 1'b0;
            ADS_CLK = 1'b1; wait_cyc(6);
            oa = {oa[16:0], ADS_SDOA};
            ob = {ob[16:0], ADS_SDOB};
            ADS_CLK = 1'b0; wait_cyc(6);
            if (stop_at == i + 1) return;
        end
        ADS_CS_N = 1'b1;
        ADS_SDI  = 1'b0;
        wait_cyc(8);
    endtask

    // CONVST pulse at cycle 0 and optionally a second one; returns BUSY high time
    task automatic conv_run(input int second, output int w);
        w = 0;
        for (int i = 0; i < 120; i++) begin
            ADS_CONVST = (i < 3) || (second > 0 && i >= second && i < second + 3);
            @(negedge CLK_100M);
            if (ADS_BUSY) w++;
        end
        ADS_CONVST = 1'b0;
    endtask

    initial begin
        cv[0] = '{16'h0004, 16, 1, 12'h000, 12'h000, 12'h000};
        cv[1] = '{16'h0002, 16, 1, 12'h000, 12'h000, 12'h000};
        cv[2] = '{16'h07FF, 16, 1, 12'h000, 12'h7FF, 12'h000};
        cv[3] = '{16'h0005, 16, 1, 12'h000, 12'h7FF, 12'h000};
        cv[4] = '{16'h07FF, 16, 1, 12'h000, 12'h7FF, 12'h7FF};
        cv[5] = '{16'h4010, 16, 1, 12'h010, 12'h7FF, 12'h7FF};
        cv[6] = '{16'h4FFF, 12, 0, 12'h010, 12'h7FF, 12'h7FF};

        rv[0] = '{16'h1234, 16'hABCD, 16'h0000, 18'h01234, 18'h2ABCD, 16'd1};
        rv[1] = '{16'h5555, 16'h0F0F, 16'h0000, 18'h15555, 18'h30F0F, 16'd2};
        rv[2] = '{16'h0001, 16'h8000, 16'h0010, 18'h10001, 18'h18000, 16'd1};
        rv[3] = '{16'hFFFF, 16'h0000, 16'h0010, 18'h2FFFF, 18'h20000, 16'd2};
        rv[4] = '{16'h1357, 16'h2468, 16'h0010, 18'h31357, 18'h32468, 16'd3};
        rv[5] = '{16'hAAAA, 16'h5555, 16'h0010, 18'h0AAAA, 18'h05555, 16'd4};
        rv[6] = '{16'hC3C3, 16'h3C3C, 16'h0010, 18'h1C3C3, 18'h13C3C, 16'd5};

        wait_cyc(4);
        chk("rst_cfg",  32'(CFG_CR),   32'h0);
        chk("rst_dac1", 32'(REFDAC1),  32'h0);
        chk("rst_dac2", 32'(REFDAC2),  32'h0);
        chk("rst_cmd",  32'(CMD_WORD), 32'h0);
        chk("rst_cnt",  32'(CONV_CNT), 32'h0);
        chk("rst_ovr",  32'(CONV_OVR), 32'h0);
        chk("rst_busy", 32'(ADS_BUSY), 32'h0);
        chk("rst_sdo",  32'({ADS_SDOA, ADS_SDOB, CMD_STB}), 32'h0);
        CLK_RST = 1'b0;
        wait_cyc(8);

        // Command decode: soft reset, pending REFDAC writes, CFG, short frame
        stb_base = stb_cnt;
        for (int i = 0; i < 7; i++) begin
            stb0 = stb_cnt;
            frame(cv[i].word, cv[i].nbits, 1'b0, 0, ga, gb);
            chk($sformatf("cmd%0d_stb", i),  32'(stb_cnt - stb0), 32'(cv[i].stb));
            chk($sformatf("cmd%0d_cfg", i),  32'(CFG_CR),  32'(cv[i].cfg));
            chk($sformatf("cmd%0d_dac1", i), 32'(REFDAC1), 32'(cv[i].r1));
            chk($sformatf("cmd%0d_dac2", i), 32'(REFDAC2), 32'(cv[i].r2));
            if (cv[i].stb != 0)
                chk($sformatf("cmd%0d_word", i), 32'(CMD_WORD), 32'(cv[i].word));
        end
        chk("cmd_stb_total", 32'(stb_cnt - stb_base), 32'd6);

        // Conversions and readout, channel tags then count tags
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                frame(16'h0004, 16, 1'b0, 0, ga, gb);
                frame(16'h0010, 16, 1'b0, 0, ga, gb);
                frame(16'h4010, 16, 1'b0, 0, ga, gb);
                frame(16'h0002, 16, 1'b0, 0, ga, gb);
                frame(16'h07FF, 16, 1'b0, 0, ga, gb);
            end
            DATA_A = rv[i].a;
            DATA_B = rv[i].b;
            conv_run(0, width);
            chk($sformatf("conv%0d_busy", i), 32'(width), 32'd40);
            chk($sformatf("conv%0d_cnt", i),  32'(CONV_CNT), 32'(rv[i].exp_cnt));
            frame(rv[i].sdi, 18, 1'b1, 0, ga, gb);
            chk($sformatf("conv%0d_sdoa", i), 32'(ga), 32'(rv[i].exp_a));
            chk($sformatf("conv%0d_sdob", i), 32'(gb), 32'(rv[i].exp_b));
        end

        // Shift registers hold and SDO is forced low while CS_N is high
        frame(16'h0010, 2, 1'b1, 2, ga, gb);
        chk("hold_sdo_lo", 32'({ADS_SDOA, ADS_SDOB}), 32'h3);
        ADS_CS_N = 1'b1; wait_cyc(8);
        chk("hold_sdo_cs_hi", 32'({ADS_SDOA, ADS_SDOB}), 32'h0);
        ADS_CS_N = 1'b0; wait_cyc(8);
        chk("hold_sdo_again", 32'({ADS_SDOA, ADS_SDOB}), 32'h3);
        ADS_CS_N = 1'b1; wait_cyc(8);

        // CONVST while busy: counted as overrun, BUSY width unaffected
        conv_run(10, width);
        chk("ovr_busy", 32'(width),    32'd40);
        chk("ovr_cnt",  32'(CONV_OVR), 32'd1);
        chk("ovr_conv", 32'(CONV_CNT), 32'd6);

        // Async reset in the middle of a frame
        frame(16'h4ABC, 16, 1'b1, 9, ga, gb);
        #2 CLK_RST = 1'b1;
        #1;
        chk("arst_cfg",  32'(CFG_CR),   32'h0);
        chk("arst_dac1", 32'(REFDAC1),  32'h0);
        chk("arst_cnt",  32'(CONV_CNT), 32'h0);
        chk("arst_ovr",  32'(CONV_OVR), 32'h0);
        chk("arst_cmd",  32'(CMD_WORD), 32'h0);
        chk("arst_outs", 32'({ADS_BUSY, ADS_SDOA, ADS_SDOB}), 32'h0);
        ADS_CS_N = 1'b1;
        ADS_CLK  = 1'b0;
        wait_cyc(3);
        CLK_RST = 1'b0;
        wait_cyc(8);
        stb0 = stb_cnt;
        frame(16'h4ABC, 16, 1'b0, 0, ga, gb);
        chk("post_stb",  32'(stb_cnt - stb0), 32'd1);
        chk("post_cfg",  32'(CFG_CR),   32'hABC);
        chk("post_word", 32'(CMD_WORD), 32'h4ABC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
